md_unit: RTL

Multi-cycle multiply/divide unit with architectural HI/LO registers, placed in the execute stage beside the ALU. It takes the same two register-file operands the ALU receives (rs value on `A`, rt value on `B`) and executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`. It holds the results in HI/LO for `mfhi`/`mflo`, and tells the core when it must stall.

---
 rtl/md_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// The result is computed in the cycle the op is accepted and parked in a
// pending register. A countdown then delays the HI/LO commit so the
// visible latency matches the modelled multiplier/divider.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_we_q, pend_we_d;

  logic        is_md;
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, sq, sr, quo_s, rem_s;
  logic [31:0] b_u_safe, quo_u, rem_u;

  // Arithmetic datapath: products and quotients from the live operands.
  // Signed divide works on magnitudes so the most-negative / -1 case
  // wraps to 0x80000000 naturally instead of overflowing.
  always_comb begin
    is_md      = (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
    a_sx       = {{32{A[31]}}, A};
    b_sx       = {{32{B[31]}}, B};
    prod_s     = a_sx * b_sx;
    prod_u     = {32'd0, A} * {32'd0, B};
    a_mag      = A[31] ? (~A + 32'd1) : A;
    b_mag      = B[31] ? (~B + 32'd1) : B;
    // A zero divisor is swapped for 1 to keep the divider defined; the
    // result is then thrown away by the pending write enable.
    b_mag_safe = (B == 32'd0) ? 32'd1 : b_mag;
    sq         = a_mag / b_mag_safe;
    sr         = a_mag % b_mag_safe;
    quo_s      = (A[31] ^ B[31]) ? (~sq + 32'd1) : sq;
    rem_s      = A[31] ? (~sr + 32'd1) : sr;
    b_u_safe   = (B == 32'd0) ? 32'd1 : B;
    quo_u      = A / b_u_safe;
    rem_u      = A % b_u_safe;
  end

  // Next-state: accept in IDLE, count down in BUSY, commit on the last cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          case (MDOp)
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              pend_we_d = 1'b1;
              cnt_d     = MULT_N;
              state_d   = S_BUSY;
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              pend_we_d = 1'b1;
              cnt_d     = MULT_N;
              state_d   = S_BUSY;
            end
            OP_DIV: begin
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
              pend_we_d = (B != 32'd0);
              cnt_d     = DIV_N;
              state_d   = S_BUSY;
            end
            OP_DIVU: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              pend_we_d = (B != 32'd0);
              cnt_d     = DIV_N;
              state_d   = S_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_we_d = 1'b0;
          cnt_d     = 4'd0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops any in-flight result.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign Busy  = (state_q == S_BUSY);
  assign Stall = Busy | (Start & is_md);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
